// File: rtl/reg_main_ctrl_if.sv
// USB register-bus port bundle between the USB front end (master) and a register block (slave).
// Strobes are single-cycle with no ready: reg_write commits write_data on the usb_clk rising edge;
// reg_read selects a byte whose value is on read_data in the same cycle or the next (registered read).
interface reg_main_ctrl_if #(
    parameter int pBYTECNT_SIZE = 7
);
    logic [7:0]               reg_address;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
    logic [7:0]               write_data;
    logic                     reg_write;
    logic                     reg_read;
    logic [7:0]               read_data;

    modport master (
        output reg_address, reg_bytecnt, write_data, reg_write, reg_read,
        input  read_data
    );

    modport slave (
        input  reg_address, reg_bytecnt, write_data, reg_write, reg_read,
        output read_data
    );
endinterface

// File: rtl/reg_main_ctrl.sv
// Main control register block: scratch registers, FPGA/target reset control, PLL bypass,
// a self-timed target-reset pulse and a free-running uptime counter with tear-free reads.
module reg_main_ctrl #(
    parameter int pBYTECNT_SIZE    = 7,
    parameter int pREGISTERED_READ = 1,
    parameter int pREG_BYTES       = 4,
    parameter int pNUM_SCRATCH     = 4
) (
    input  logic              usb_clk,
    input  logic              reset_pin_n,
    reg_main_ctrl_if.slave    bus,
    output logic              fpga_reset,
    output logic              target_reset,
    output logic              reg_pll_bypass,
    output logic              pulse_busy,
    output logic              pulse_state_dbg
);
    localparam int RW = pREG_BYTES * 8;

    localparam logic [7:0] A_PLL     = 8'h01;
    localparam logic [7:0] A_FRST    = 8'h02;
    localparam logic [7:0] A_TRST    = 8'h03;
    localparam logic [7:0] A_LEN     = 8'h04;
    localparam logic [7:0] A_UPTIME  = 8'h05;
    localparam logic [7:0] A_STATUS  = 8'h06;
    localparam logic [7:0] A_SCRATCH = 8'h10;

    typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} pulse_state_t;

    function automatic logic [7:0] byte_of(input logic [RW-1:0] v,
                                           input logic [pBYTECNT_SIZE-1:0] idx);
        byte_of = 8'h00;
        for (int b = 0; b < pREG_BYTES; b++)
            if (idx == pBYTECNT_SIZE'(b)) byte_of = v[b*8 +: 8];
    endfunction

    logic              reg_fpga_reset;
    logic              reg_target_reset;
    logic [RW-1:0]     pulse_len;
    logic [RW-1:0]     pulse_cnt;
    logic [RW-1:0]     cnt_nxt;
    logic [RW-1:0]     uptime;
    logic [RW-1:0]     uptime_snap;
    logic [RW-1:0]     scratch [pNUM_SCRATCH];
    logic [RW-1:0]     len_new;
    logic [7:0]        rd_sel;
    pulse_state_t      state;
    pulse_state_t      state_nxt;

    logic bc0, len_wr, len_top_wr, snap_take;

    assign bc0        = (bus.reg_bytecnt == '0);
    assign len_wr     = bus.reg_write && (bus.reg_address == A_LEN);
    assign len_top_wr = len_wr && (bus.reg_bytecnt == pBYTECNT_SIZE'(pREG_BYTES - 1));
    assign snap_take  = bus.reg_read && (bus.reg_address == A_UPTIME) && bc0;

    assign fpga_reset      = ~reset_pin_n | reg_fpga_reset;
    assign pulse_busy      = (state == PULSE) && !fpga_reset;
    assign target_reset    = fpga_reset | reg_target_reset | pulse_busy;
    assign pulse_state_dbg = state;

    // Length as it will be after this write lands, so the pulse starts from the new value.
    always_comb begin
        len_new = pulse_len;
        len_new[RW-1 -: 8] = bus.write_data;
    end

    // These two survive fpga_reset: only the pin clears them.
    always_ff @(posedge usb_clk or negedge reset_pin_n) begin
        if (!reset_pin_n) begin
            reg_pll_bypass <= 1'b0;
            reg_fpga_reset <= 1'b0;
        end else if (bus.reg_write && bc0) begin
            if (bus.reg_address == A_PLL)  reg_pll_bypass <= bus.write_data[0];
            if (bus.reg_address == A_FRST) reg_fpga_reset <= bus.write_data[0];
        end
    end

    always_ff @(posedge usb_clk or negedge reset_pin_n) begin
        if (!reset_pin_n) begin
            reg_target_reset <= 1'b0;
            pulse_len        <= '0;
            uptime           <= '0;
            uptime_snap      <= '0;
            for (int i = 0; i < pNUM_SCRATCH; i++) scratch[i] <= '0;
        end else if (reg_fpga_reset) begin
            reg_target_reset <= 1'b0;
            pulse_len        <= '0;
            uptime           <= '0;
            uptime_snap      <= '0;
            for (int i = 0; i < pNUM_SCRATCH; i++) scratch[i] <= '0;
        end else begin
            uptime <= uptime + 1'b1;
            if (snap_take) uptime_snap <= uptime;
            if (bus.reg_write && bc0 && bus.reg_address == A_TRST)
                reg_target_reset <= bus.write_data[0];
            for (int b = 0; b < pREG_BYTES; b++)
                if (len_wr && bus.reg_bytecnt == pBYTECNT_SIZE'(b))
                    pulse_len[b*8 +: 8] <= bus.write_data;
            for (int i = 0; i < pNUM_SCRATCH; i++)
                for (int b = 0; b < pREG_BYTES; b++)
                    if (bus.reg_write && bus.reg_address == A_SCRATCH + 8'(i) &&
                        bus.reg_bytecnt == pBYTECNT_SIZE'(b))
                        scratch[i][b*8 +: 8] <= bus.write_data;
        end
    end

    always_ff @(posedge usb_clk or negedge reset_pin_n) begin
        if (!reset_pin_n) begin
            state     <= IDLE;
            pulse_cnt <= '0;
        end else if (reg_fpga_reset) begin
            state     <= IDLE;
            pulse_cnt <= '0;
        end else begin
            state     <= state_nxt;
            pulse_cnt <= cnt_nxt;
        end
    end

    // Busy for exactly L cycles: count loads L, leaves PULSE on the cycle it reads 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = pulse_cnt;
        case (state)
            IDLE: begin
                if (len_top_wr && len_new != '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = len_new;
                end
            end
            PULSE: begin
                cnt_nxt = pulse_cnt - 1'b1;
                if (pulse_cnt == RW'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_sel = 8'h00;
        if (bus.reg_read) begin
            case (bus.reg_address)
                A_PLL:    if (bc0) rd_sel = {7'b0, reg_pll_bypass};
                A_FRST:   if (bc0) rd_sel = {7'b0, reg_fpga_reset};
                A_TRST:   if (bc0) rd_sel = {7'b0, reg_target_reset};
                A_LEN:    rd_sel = byte_of(pulse_len, bus.reg_bytecnt);
                A_UPTIME: rd_sel = bc0 ? uptime[7:0] : byte_of(uptime_snap, bus.reg_bytecnt);
                A_STATUS: if (bc0) rd_sel = {5'b0, pulse_busy, reg_target_reset, reg_fpga_reset};
                default: begin
                    for (int i = 0; i < pNUM_SCRATCH; i++)
                        if (bus.reg_address == A_SCRATCH + 8'(i))
                            rd_sel = byte_of(scratch[i], bus.reg_bytecnt);
                end
            endcase
        end
    end

    generate
        if (pREGISTERED_READ != 0) begin : g_rd_reg
            logic [7:0] rd_q;
            always_ff @(posedge usb_clk or negedge reset_pin_n) begin
                if (!reset_pin_n) rd_q <= 8'h00;
                else              rd_q <= rd_sel;
            end
            assign bus.read_data = rd_q;
        end else begin : g_rd_comb
            assign bus.read_data = rd_sel;
        end
    endgenerate
endmodule

// File: tb/tb_reg_main_ctrl.sv
// Bench for reg_main_ctrl: registered- and combinational-read instances share one stimulus
// stream; a behavioural model feeds expected-read queues drained by a monitor on the falling edge.
module tb_reg_main_ctrl;
  localparam int BC = 7;
  localparam int RB = 4;
  localparam int NS = 4;

  logic usb_clk = 1'b0;
  logic reset_pin_n;
  always #5 usb_clk = ~usb_clk;

  reg_main_ctrl_if #(.pBYTECNT_SIZE(BC)) bus ();
  reg_main_ctrl_if #(.pBYTECNT_SIZE(BC)) bus_c ();

  assign bus_c.reg_address = bus.reg_address;
  assign bus_c.reg_bytecnt = bus.reg_bytecnt;
  assign bus_c.write_data  = bus.write_data;
  assign bus_c.reg_write   = bus.reg_write;
  assign bus_c.reg_read    = bus.reg_read;

  logic fpga_reset, target_reset, reg_pll_bypass, pulse_busy, dbg;
  logic fpga_reset_c, target_reset_c, reg_pll_bypass_c, pulse_busy_c, dbg_c;

  reg_main_ctrl #(.pBYTECNT_SIZE(BC), .pREGISTERED_READ(1), .pREG_BYTES(RB), .pNUM_SCRATCH(NS)) dut (
    .usb_clk(usb_clk), .reset_pin_n(reset_pin_n), .bus(bus),
    .fpga_reset(fpga_reset), .target_reset(target_reset), .reg_pll_bypass(reg_pll_bypass),
    .pulse_busy(pulse_busy), .pulse_state_dbg(dbg));

  reg_main_ctrl #(.pBYTECNT_SIZE(BC), .pREGISTERED_READ(0), .pREG_BYTES(RB), .pNUM_SCRATCH(NS)) dut_c (
    .usb_clk(usb_clk), .reset_pin_n(reset_pin_n), .bus(bus_c),
    .fpga_reset(fpga_reset_c), .target_reset(target_reset_c), .reg_pll_bypass(reg_pll_bypass_c),
    .pulse_busy(pulse_busy_c), .pulse_state_dbg(dbg_c));

  // reference model state
  logic [31:0] scratch_m [NS];
  logic        pll_m, frst_m, trst_m;
  logic [31:0] plen_m, uptime_m, snap_m, rem_m;

  logic [7:0] exp_q[$];
  logic [7:0] exp_c_q[$];
  logic exp_busy, exp_frst, exp_trst, exp_pll, exp_dbg;
  bit   rd_prev = 1'b0;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] byte_m(input logic [31:0] v, input int bc);
    if (bc >= 0 && bc < RB) return v[8*bc +: 8];
    return 8'h00;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a, input int bc);
    logic busy;
    busy = (rem_m != 0) && !frst_m;
    case (a)
      8'h01: return (bc == 0) ? {7'b0, pll_m} : 8'h00;
      8'h02: return (bc == 0) ? {7'b0, frst_m} : 8'h00;
      8'h03: return (bc == 0) ? {7'b0, trst_m} : 8'h00;
      8'h04: return byte_m(plen_m, bc);
      8'h05: return (bc == 0) ? uptime_m[7:0] : byte_m(snap_m, bc);
      8'h06: return (bc == 0) ? {5'b0, busy, trst_m, frst_m} : 8'h00;
      default: begin
        if (a >= 8'h10 && a < 8'h10 + NS) return byte_m(scratch_m[a - 8'h10], bc);
        return 8'h00;
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) scratch_m[i] = '0;
    pll_m = 0; frst_m = 0; trst_m = 0;
    plen_m = 0; uptime_m = 0; snap_m = 0; rem_m = 0;
  endtask

  // One bus cycle: drive, record expectations, advance the model across the rising edge.
  task automatic do_cycle(input logic [7:0] a, input int bc, input logic [7:0] wd,
                          input bit wr, input bit rd);
    logic [7:0] v;
    bit idle_before;
    bus.reg_address = a;
    bus.reg_bytecnt = BC'(bc);
    bus.write_data  = wd;
    bus.reg_write   = wr;
    bus.reg_read    = rd;
    exp_busy = (rem_m != 0) && !frst_m;
    exp_frst = frst_m;
    exp_trst = frst_m | trst_m | exp_busy;
    exp_pll  = pll_m;
    exp_dbg  = (rem_m != 0);
    if (rd) begin
      v = model_read(a, bc);
      exp_q.push_back(v);
      exp_c_q.push_back(v);
    end
    @(posedge usb_clk);
    if (frst_m) begin
      for (int i = 0; i < NS; i++) scratch_m[i] = '0;
      trst_m = 0; plen_m = 0; uptime_m = 0; snap_m = 0; rem_m = 0;
    end else begin
      if (rd && a == 8'h05 && bc == 0) snap_m = uptime_m;
      uptime_m = uptime_m + 1;
      idle_before = (rem_m == 0);
      if (rem_m != 0) rem_m = rem_m - 1;
      if (wr && a == 8'h04 && bc < RB) begin
        plen_m[8*bc +: 8] = wd;
        if (bc == RB - 1 && idle_before && plen_m != 0) rem_m = plen_m;
      end
      if (wr && a == 8'h03 && bc == 0) trst_m = wd[0];
      if (wr && a >= 8'h10 && a < 8'h10 + NS && bc < RB) scratch_m[a - 8'h10][8*bc +: 8] = wd;
    end
    if (wr && bc == 0 && a == 8'h01) pll_m = wd[0];
    if (wr && bc == 0 && a == 8'h02) frst_m = wd[0];
    rd_prev = rd;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(8'h00, 0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [31:0] v);
    for (int b = 0; b < RB; b++) do_cycle(a, b, v[8*b +: 8], 1'b1, 1'b0);
  endtask

  task automatic read_reg(input logic [7:0] a, input int nbytes);
    for (int b = 0; b < nbytes; b++) do_cycle(a, b, 8'h00, 1'b0, 1'b1);
  endtask

  // Monitor: compares outputs and drains the expected-read queues.
  always @(negedge usb_clk) begin
    if (mon_en) begin
      check("fpga_reset", {7'b0, fpga_reset}, {7'b0, exp_frst});
      check("target_reset", {7'b0, target_reset}, {7'b0, exp_trst});
      check("pulse_busy", {7'b0, pulse_busy}, {7'b0, exp_busy});
      check("pll_bypass", {7'b0, reg_pll_bypass}, {7'b0, exp_pll});
      check("pulse_state", {7'b0, dbg}, {7'b0, exp_dbg});
      check("c_target_reset", {7'b0, target_reset_c}, {7'b0, exp_trst});
      check("c_pulse_busy", {7'b0, pulse_busy_c}, {7'b0, exp_busy});
      if (bus.reg_read) begin
        if (exp_c_q.size() == 0) check("c_read_queue_empty", 8'h01, 8'h00);
        else check("c_read_data", bus_c.read_data, exp_c_q.pop_front());
      end else check("c_read_idle_zero", bus_c.read_data, 8'h00);
      if (rd_prev) begin
        if (exp_q.size() == 0) check("read_queue_empty", 8'h01, 8'h00);
        else check("read_data", bus.read_data, exp_q.pop_front());
      end else check("read_idle_zero", bus.read_data, 8'h00);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] atab [12];
    logic [7:0] a;
    int bc;
    atab = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    bus.reg_address = 0; bus.reg_bytecnt = 0; bus.write_data = 0;
    bus.reg_write = 0; bus.reg_read = 0;
    reset_pin_n = 1'b1;
    #1 reset_pin_n = 1'b0;
    #1;
    check("rst_fpga_reset", {7'b0, fpga_reset}, 8'h01);
    check("rst_target_reset", {7'b0, target_reset}, 8'h01);
    check("rst_pll_bypass", {7'b0, reg_pll_bypass}, 8'h00);
    check("rst_pulse_busy", {7'b0, pulse_busy}, 8'h00);
    check("rst_read_data", bus.read_data, 8'h00);
    @(posedge usb_clk); @(posedge usb_clk); #1;
    reset_pin_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // every register reads zero (uptime byte 0 excepted) after reset
    for (int i = 0; i < 12; i++) read_reg(atab[i], 5);

    // scratch multi-byte access, out-of-range byte and unmapped index
    write_reg(8'h12, 32'hA5B6C7D8);
    do_cycle(8'h12, 4, 8'hEE, 1'b1, 1'b0);
    read_reg(8'h12, 5);
    do_cycle(8'h10 + NS, 0, 8'h77, 1'b1, 1'b0);
    read_reg(8'h10 + NS, 2);
    do_cycle(8'h10, 0, 8'h5A, 1'b1, 1'b1);
    read_reg(8'h10, 1);

    // 5-cycle pulse; mid-pulse rewrite to 100 must not extend it; length 0 gives none
    write_reg(8'h04, 32'd5);
    write_reg(8'h04, 32'd100);
    idle(6);
    read_reg(8'h04, 4);
    write_reg(8'h04, 32'd0);
    idle(4);

    // target reset level
    do_cycle(8'h03, 0, 8'h01, 1'b1, 1'b0);
    read_reg(8'h06, 1);
    do_cycle(8'h03, 0, 8'h00, 1'b1, 1'b0);

    // long pulse aborted by FPGA_RESET, scratch cleared, PLL bypass kept
    do_cycle(8'h01, 0, 8'h01, 1'b1, 1'b0);
    write_reg(8'h11, 32'h11223344);
    write_reg(8'h04, 32'd1000);
    idle(10);
    do_cycle(8'h02, 0, 8'h01, 1'b1, 1'b0);
    idle(3);
    read_reg(8'h06, 1);
    read_reg(8'h11, 4);
    read_reg(8'h01, 1);
    do_cycle(8'h02, 0, 8'h00, 1'b1, 1'b0);
    idle(3);
    read_reg(8'h04, 4);
    read_reg(8'h01, 1);
    write_reg(8'h13, 32'hCAFE0042);
    read_reg(8'h13, 4);

    // uptime wrap: byte reads after the wrap still return the byte-0 snapshot
    force dut.uptime = 32'hFFFF_FFFA;
    force dut_c.uptime = 32'hFFFF_FFFA;
    #1;
    release dut.uptime;
    release dut_c.uptime;
    uptime_m = 32'hFFFF_FFFA;
    for (int k = 0; k < 3; k++) read_reg(8'h05, 4);
    idle(1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      a = atab[$urandom_range(0, 11)];
      bc = $urandom_range(0, 4);
      if (a == 8'h04) do_cycle(a, bc, (bc == 0) ? 8'($urandom_range(1, 20)) : 8'h00,
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (a == 8'h02) do_cycle(a, bc, 8'($urandom_range(0, 1)),
                                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      else do_cycle(a, bc, 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    do_cycle(8'h02, 0, 8'h00, 1'b1, 1'b0);

    // pin reset in the middle of a pulse acts immediately
    write_reg(8'h04, 32'd50);
    idle(4);
    mon_en = 1'b0;
    #2 reset_pin_n = 1'b0;
    #1;
    check("pin_fpga_reset", {7'b0, fpga_reset}, 8'h01);
    check("pin_target_reset", {7'b0, target_reset}, 8'h01);
    check("pin_pulse_busy", {7'b0, pulse_busy}, 8'h00);
    check("pin_pll_bypass", {7'b0, reg_pll_bypass}, 8'h00);
    check("pin_read_data", bus.read_data, 8'h00);
    @(posedge usb_clk); @(posedge usb_clk); #1;
    reset_pin_n = 1'b1;
    model_reset();
    rd_prev = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 12; i++) read_reg(atab[i], 4);
    idle(3);
    mon_en = 1'b0;
    check("exp_q_drained", 8'(exp_q.size()), 8'h00);
    check("exp_c_q_drained", 8'(exp_c_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
